// File: rtl/fwd_lookup_table.sv
// +--------------------------------------------------------------------------+
// | fwd_lookup_table: host-programmed lookup table with pipelined forwarding   |
// | lookups, per-entry valid bits, flush sweep and saturating hit/miss stats. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

`ifndef CHANNEL_NUM
`define CHANNEL_NUM 4
`endif

module fwd_lookup_table #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 12 + `CHANNEL_NUM,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_wren,
  input  logic              host_inv,
  input  logic              host_rden,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ready,
  output logic              host_rvalid,
  output logic              host_rhit,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              flush_req,
  output logic              flush_busy,
  input  logic              fwd_rden,
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_rvalid,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_rdata,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int               c_depth    = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] c_idx_last = {ADDR_W{1'b1}};

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_flush_idx;
  logic [c_depth-1:0]  r_valid;
  logic [DATA_W-1:0]   r_mem [c_depth];

  logic                w_wr;
  logic                w_inv;
  logic                w_host_rd;
  logic                w_host_hit;
  logic [DATA_W-1:0]   w_host_data;
  logic                w_fwd_hit;
  logic [DATA_W-1:0]   w_fwd_data;

  assign w_wr      = host_wren & host_ready;
  assign w_inv     = host_inv  & host_ready;
  assign w_host_rd = host_rden & host_ready;

  // Write-first view of the table: an accepted write or invalidate in this
  // cycle is visible to reads issued in the same cycle.
  always_comb begin
    w_host_hit  = r_valid[host_addr];
    w_host_data = r_mem[host_addr];
    if (w_wr) begin
      w_host_hit  = 1'b1;
      w_host_data = host_wdata;
    end else if (w_inv) begin
      w_host_hit  = 1'b0;
    end
    if (!w_host_hit) w_host_data = '0;
  end

  always_comb begin
    w_fwd_hit  = r_valid[fwd_addr];
    w_fwd_data = r_mem[fwd_addr];
    if (w_wr && (host_addr == fwd_addr)) begin
      w_fwd_hit  = 1'b1;
      w_fwd_data = host_wdata;
    end else if (w_inv && (host_addr == fwd_addr)) begin
      w_fwd_hit  = 1'b0;
    end
    if (!w_fwd_hit) w_fwd_data = '0;
  end

  // Payload storage is not reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[host_addr] <= host_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_flush_idx <= '0;
      r_valid     <= '0;
      host_ready  <= 1'b1;
      flush_busy  <= 1'b0;
      host_rvalid <= 1'b0;
      host_rhit   <= 1'b0;
      host_rdata  <= '0;
      fwd_rvalid  <= 1'b0;
      fwd_hit     <= 1'b0;
      fwd_rdata   <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_inv) r_valid[host_addr] <= 1'b0;
          if (w_wr)  r_valid[host_addr] <= 1'b1;
          if (flush_req) begin
            r_state     <= S_FLUSH;
            r_flush_idx <= '0;
            host_ready  <= 1'b0;
            flush_busy  <= 1'b1;
          end
        end
        S_FLUSH: begin
          r_valid[r_flush_idx] <= 1'b0;
          r_flush_idx          <= r_flush_idx + ADDR_W'(1);
          if (r_flush_idx == c_idx_last) begin
            r_state    <= S_IDLE;
            host_ready <= 1'b1;
            flush_busy <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          host_ready <= 1'b1;
          flush_busy <= 1'b0;
        end
      endcase

      host_rvalid <= w_host_rd;
      host_rhit   <= w_host_rd & w_host_hit;
      host_rdata  <= w_host_rd ? w_host_data : '0;
      fwd_rvalid  <= fwd_rden;
      fwd_hit     <= fwd_rden & w_fwd_hit;
      fwd_rdata   <= fwd_rden ? w_fwd_data : '0;

      // Counters advance on the same edge that registers the lookup result.
      if (cnt_clr) begin
        hit_cnt  <= '0;
        miss_cnt <= '0;
      end else if (fwd_rden) begin
        if (w_fwd_hit) begin
          if (hit_cnt != c_cnt_max) hit_cnt <= hit_cnt + c_cnt_one;
        end else begin
          if (miss_cnt != c_cnt_max) miss_cnt <= miss_cnt + c_cnt_one;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fwd_lookup_table.sv
// +--------------------------------------------------------------------------+
// | tb_fwd_lookup_table: randomized and directed bench for fwd_lookup_table.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

`ifndef CHANNEL_NUM
`define CHANNEL_NUM 4
`endif

module tb_fwd_lookup_table;

  localparam int ADDR_W  = 8;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int DATA_W  = 12 + `CHANNEL_NUM;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              host_wren = 1'b0, host_inv = 1'b0, host_rden = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [DATA_W-1:0] host_wdata = '0;
  logic              host_ready, host_rvalid, host_rhit;
  logic [DATA_W-1:0] host_rdata;
  logic              flush_req = 1'b0;
  logic              flush_busy;
  logic              fwd_rden = 1'b0;
  logic [ADDR_W-1:0] fwd_addr = '0;
  logic              fwd_rvalid, fwd_hit;
  logic [DATA_W-1:0] fwd_rdata;
  logic              cnt_clr = 1'b0;
  logic [CNT_W-1:0]  hit_cnt, miss_cnt;

  fwd_lookup_table #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_wren(host_wren), .host_inv(host_inv), .host_rden(host_rden),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ready(host_ready),
    .host_rvalid(host_rvalid), .host_rhit(host_rhit), .host_rdata(host_rdata),
    .flush_req(flush_req), .flush_busy(flush_busy),
    .fwd_rden(fwd_rden), .fwd_addr(fwd_addr), .fwd_rvalid(fwd_rvalid),
    .fwd_hit(fwd_hit), .fwd_rdata(fwd_rdata),
    .cnt_clr(cnt_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: table contents, outstanding flush cycles and counts.
  bit                m_valid [DEPTH];
  logic [DATA_W-1:0] m_data  [DEPTH];
  int                m_flush_left;
  int                m_hit, m_miss;

  logic              exp_host_rvalid, exp_host_rhit, exp_fwd_rvalid, exp_fwd_hit;
  logic [DATA_W-1:0] exp_host_rdata, exp_fwd_rdata;
  logic              exp_ready, exp_busy;

  task automatic clear_inputs();
    host_wren = 0; host_inv = 0; host_rden = 0; host_addr = '0; host_wdata = '0;
    flush_req = 0; fwd_rden = 0; fwd_addr = '0; cnt_clr = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
    m_flush_left = 0; m_hit = 0; m_miss = 0;
    exp_host_rvalid = 0; exp_host_rhit = 0; exp_host_rdata = '0;
    exp_fwd_rvalid = 0; exp_fwd_hit = 0; exp_fwd_rdata = '0;
    exp_ready = 1; exp_busy = 0;
  endtask

  function automatic void model_lookup(input logic [ADDR_W-1:0] a, input bit wr, input bit inv,
                                       output bit h, output logic [DATA_W-1:0] d);
    if (wr && host_addr == a) begin h = 1; d = host_wdata; end
    else if (inv && host_addr == a) begin h = 0; d = '0; end
    else begin h = m_valid[a]; d = h ? m_data[a] : '0; end
  endfunction

  // Predict the outputs of the current inputs, then advance one clock.
  task automatic tick();
    bit ready, wr, inv, h;
    logic [DATA_W-1:0] d;
    ready = (m_flush_left == 0);
    wr  = host_wren && ready;
    inv = host_inv && ready;
    model_lookup(host_addr, wr, inv, h, d);
    exp_host_rvalid = host_rden && ready;
    exp_host_rhit   = exp_host_rvalid && h;
    exp_host_rdata  = exp_host_rvalid ? d : '0;
    model_lookup(fwd_addr, wr, inv, h, d);
    exp_fwd_rvalid = fwd_rden;
    exp_fwd_hit    = fwd_rden && h;
    exp_fwd_rdata  = fwd_rden ? d : '0;
    if (cnt_clr) begin m_hit = 0; m_miss = 0; end
    else if (fwd_rden) begin
      if (h) m_hit  = (m_hit  < CNT_MAX) ? m_hit + 1  : CNT_MAX;
      else   m_miss = (m_miss < CNT_MAX) ? m_miss + 1 : CNT_MAX;
    end
    if (m_flush_left > 0) begin
      m_valid[DEPTH - m_flush_left] = 0;
      m_flush_left--;
    end else begin
      if (inv) m_valid[host_addr] = 0;
      if (wr) begin m_valid[host_addr] = 1; m_data[host_addr] = host_wdata; end
      if (flush_req) m_flush_left = DEPTH;
    end
    exp_ready = (m_flush_left == 0);
    exp_busy  = !exp_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (host_ready !== 1'b1) begin failures++; $display("FAIL reset_host_ready got=%b want=1", host_ready); end
    checks++; if (flush_busy !== 1'b0) begin failures++; $display("FAIL reset_flush_busy got=%b want=0", flush_busy); end
    checks++; if (host_rvalid !== 1'b0 || host_rhit !== 1'b0 || host_rdata !== '0) begin
      failures++; $display("FAIL reset_host_read got=%b/%b/%h want=0/0/0", host_rvalid, host_rhit, host_rdata); end
    checks++; if (fwd_rvalid !== 1'b0 || fwd_hit !== 1'b0 || fwd_rdata !== '0) begin
      failures++; $display("FAIL reset_fwd_read got=%b/%b/%h want=0/0/0", fwd_rvalid, fwd_hit, fwd_rdata); end
    checks++; if (hit_cnt !== '0 || miss_cnt !== '0) begin
      failures++; $display("FAIL reset_counters got=%0d/%0d want=0/0", hit_cnt, miss_cnt); end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_miss_after_reset();
    fwd_rden = 1; fwd_addr = 8'h10;
    tick();
    clear_inputs();
    checks++; if (fwd_rvalid !== 1'b1 || fwd_hit !== 1'b0 || fwd_rdata !== '0) begin
      failures++; $display("FAIL first_miss got=%b/%b/%h want=1/0/0", fwd_rvalid, fwd_hit, fwd_rdata); end
    checks++; if (miss_cnt !== 4'd1) begin failures++; $display("FAIL first_miss_cnt got=%0d want=1", miss_cnt); end
    tick();
    checks++; if (fwd_rvalid !== 1'b0 || fwd_hit !== 1'b0 || fwd_rdata !== '0) begin
      failures++; $display("FAIL rvalid_single_cycle got=%b/%b/%h want=0/0/0", fwd_rvalid, fwd_hit, fwd_rdata); end
  endtask

  task automatic test_write_read();
    host_wren = 1; host_addr = 8'h10; host_wdata = DATA_W'(12'h0A5);
    tick();
    clear_inputs();
    fwd_rden = 1; fwd_addr = 8'h10;
    tick();
    clear_inputs();
    checks++; if (fwd_hit !== 1'b1 || fwd_rdata !== DATA_W'(12'h0A5)) begin
      failures++; $display("FAIL write_read got=%b/%h want=1/0a5", fwd_hit, fwd_rdata); end
    checks++; if (hit_cnt !== 4'd1) begin failures++; $display("FAIL write_read_hit_cnt got=%0d want=1", hit_cnt); end
  endtask

  task automatic test_bypass();
    host_wren = 1; host_addr = 8'h22; host_wdata = DATA_W'(12'h123);
    host_rden = 1; fwd_rden = 1; fwd_addr = 8'h22;
    tick();
    clear_inputs();
    checks++; if (fwd_hit !== 1'b1 || fwd_rdata !== DATA_W'(12'h123)) begin
      failures++; $display("FAIL bypass_fwd got=%b/%h want=1/123", fwd_hit, fwd_rdata); end
    checks++; if (host_rvalid !== 1'b1 || host_rhit !== 1'b1 || host_rdata !== DATA_W'(12'h123)) begin
      failures++; $display("FAIL bypass_host got=%b/%b/%h want=1/1/123", host_rvalid, host_rhit, host_rdata); end
    host_inv = 1; host_addr = 8'h10; fwd_rden = 1; fwd_addr = 8'h10;
    tick();
    clear_inputs();
    checks++; if (fwd_rvalid !== 1'b1 || fwd_hit !== 1'b0 || fwd_rdata !== '0) begin
      failures++; $display("FAIL bypass_inv got=%b/%b/%h want=1/0/0", fwd_rvalid, fwd_hit, fwd_rdata); end
  endtask

  task automatic test_flush();
    int busy_cycles;
    for (int i = 0; i < 4; i++) begin
      host_wren = 1; host_addr = ADDR_W'(8'h30 + i); host_wdata = DATA_W'($urandom);
      tick();
    end
    host_addr = 8'h34; host_wdata = DATA_W'($urandom); flush_req = 1;
    tick();
    clear_inputs();
    checks++; if (flush_busy !== 1'b1 || host_ready !== 1'b0) begin
      failures++; $display("FAIL flush_start got=%b/%b want=1/0", flush_busy, host_ready); end
    busy_cycles = 1;
    host_wren = 1; host_addr = 8'h40; host_wdata = DATA_W'(12'h007);
    while (flush_busy === 1'b1 && busy_cycles < 300) begin
      fwd_rden = 1; fwd_addr = ADDR_W'(8'h30 + $urandom_range(0, 4));
      flush_req = ($urandom_range(0, 15) == 0);
      tick();
      checks++; if (fwd_hit !== exp_fwd_hit || fwd_rdata !== exp_fwd_rdata) begin
        failures++; $display("FAIL flush_lookup addr=%h got=%b/%h want=%b/%h", fwd_addr, fwd_hit, fwd_rdata, exp_fwd_hit, exp_fwd_rdata); end
      if (flush_busy === 1'b1) begin
        busy_cycles++;
        checks++; if (host_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b want=0", host_ready); end
      end
    end
    clear_inputs();
    checks++; if (busy_cycles != DEPTH) begin failures++; $display("FAIL flush_length got=%0d want=%0d", busy_cycles, DEPTH); end
    for (int i = 0; i < 6; i++) begin
      fwd_rden = 1; fwd_addr = (i == 5) ? ADDR_W'(8'h40) : ADDR_W'(8'h30 + i);
      tick();
      checks++; if (fwd_hit !== 1'b0 || fwd_rdata !== '0) begin
        failures++; $display("FAIL post_flush_miss addr=%h got=%b/%h want=0/0", fwd_addr, fwd_hit, fwd_rdata); end
    end
    clear_inputs();
  endtask

  task automatic test_wr_inv_priority();
    logic [DATA_W-1:0] d;
    d = DATA_W'($urandom);
    host_wren = 1; host_inv = 1; host_addr = 8'h05; host_wdata = d;
    tick();
    clear_inputs();
    host_rden = 1; host_addr = 8'h05;
    tick();
    checks++; if (host_rhit !== 1'b1 || host_rdata !== d) begin
      failures++; $display("FAIL wr_over_inv got=%b/%h want=1/%h", host_rhit, host_rdata, d); end
    clear_inputs();
    host_inv = 1; host_addr = 8'h05;
    tick();
    clear_inputs();
    host_rden = 1; host_addr = 8'h05;
    tick();
    clear_inputs();
    checks++; if (host_rvalid !== 1'b1 || host_rhit !== 1'b0 || host_rdata !== '0) begin
      failures++; $display("FAIL inv_alone got=%b/%b/%h want=1/0/0", host_rvalid, host_rhit, host_rdata); end
  endtask

  task automatic test_counter_sat();
    cnt_clr = 1; host_wren = 1; host_addr = 8'h50; host_wdata = DATA_W'($urandom);
    tick();
    clear_inputs();
    for (int i = 0; i < 20; i++) begin
      fwd_rden = 1; fwd_addr = 8'h50;
      tick();
      checks++; if (hit_cnt !== CNT_W'(m_hit)) begin
        failures++; $display("FAIL hit_cnt_step i=%0d got=%0d want=%0d", i, hit_cnt, m_hit); end
    end
    checks++; if (hit_cnt !== 4'd15) begin failures++; $display("FAIL hit_cnt_sat got=%0d want=15", hit_cnt); end
    cnt_clr = 1;
    tick();
    clear_inputs();
    checks++; if (hit_cnt !== 4'd0 || miss_cnt !== 4'd0) begin
      failures++; $display("FAIL cnt_clr_wins got=%0d/%0d want=0/0", hit_cnt, miss_cnt); end
    for (int i = 0; i < 20; i++) begin
      fwd_rden = 1; fwd_addr = 8'hE0;
      tick();
    end
    clear_inputs();
    checks++; if (miss_cnt !== 4'd15 || hit_cnt !== 4'd0) begin
      failures++; $display("FAIL miss_cnt_sat got=%0d/%0d want=15/0", miss_cnt, hit_cnt); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 900; n++) begin
      host_wren  = ($urandom_range(0, 3) == 0);
      host_inv   = ($urandom_range(0, 5) == 0);
      host_rden  = ($urandom_range(0, 2) == 0);
      host_addr  = ADDR_W'($urandom_range(0, 7));
      host_wdata = DATA_W'($urandom);
      fwd_rden   = ($urandom_range(0, 1) == 0);
      fwd_addr   = ADDR_W'($urandom_range(0, 7));
      flush_req  = ($urandom_range(0, 299) == 0);
      cnt_clr    = ($urandom_range(0, 39) == 0);
      tick();
      checks++; if (host_ready !== exp_ready || flush_busy !== exp_busy) begin
        failures++; $display("FAIL rnd_state n=%0d got=%b/%b want=%b/%b", n, host_ready, flush_busy, exp_ready, exp_busy); end
      checks++; if (host_rvalid !== exp_host_rvalid || host_rhit !== exp_host_rhit || host_rdata !== exp_host_rdata) begin
        failures++; $display("FAIL rnd_host n=%0d got=%b/%b/%h want=%b/%b/%h", n, host_rvalid, host_rhit, host_rdata,
                             exp_host_rvalid, exp_host_rhit, exp_host_rdata); end
      checks++; if (fwd_rvalid !== exp_fwd_rvalid || fwd_hit !== exp_fwd_hit || fwd_rdata !== exp_fwd_rdata) begin
        failures++; $display("FAIL rnd_fwd n=%0d got=%b/%b/%h want=%b/%b/%h", n, fwd_rvalid, fwd_hit, fwd_rdata,
                             exp_fwd_rvalid, exp_fwd_hit, exp_fwd_rdata); end
      checks++; if (hit_cnt !== CNT_W'(m_hit) || miss_cnt !== CNT_W'(m_miss)) begin
        failures++; $display("FAIL rnd_cnt n=%0d got=%0d/%0d want=%0d/%0d", n, hit_cnt, miss_cnt, m_hit, m_miss); end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_flush();
    host_wren = 1; host_addr = 8'h60; host_wdata = DATA_W'($urandom);
    tick();
    clear_inputs();
    if (m_flush_left == 0) flush_req = 1;
    tick();
    clear_inputs();
    repeat (10) tick();
    rst_n = 0;
    #1;
    model_reset();
    checks++; if (flush_busy !== 1'b0 || host_ready !== 1'b1) begin
      failures++; $display("FAIL reset_mid_flush got=%b/%b want=0/1", flush_busy, host_ready); end
    @(posedge clk); #1;
    rst_n = 1;
    tick();
    fwd_rden = 1; fwd_addr = 8'h60;
    tick();
    clear_inputs();
    checks++; if (fwd_hit !== 1'b0 || flush_busy !== 1'b0) begin
      failures++; $display("FAIL reset_cleared_valid got=%b/%b want=0/0", fwd_hit, flush_busy); end
  endtask

  initial begin
    test_reset();
    model_reset();
    test_miss_after_reset();
    test_write_read();
    test_bypass();
    test_flush();
    test_wr_inv_priority();
    test_counter_sat();
    test_random();
    test_reset_mid_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
